ddr3_native_arbiter: RTL and testbench

- Sits between fifo_ctrl and the MIG DDR3 native user interface, in the ui_clk domain.
- Arbitrates between write-burst requests (wr_data_req) and read-burst requests (rd_data_req).
- Takes burst command, length and base address from fifo_ctrl's cmd outputs, then issues per-beat app commands. Moves write data from the write FIFO to app_wdf and read data from app_rd to the read FIFO.
- Pulses the matching cmd_rden when a burst completes, so fifo_ctrl advances its address.

---
 rtl/ddr3_native_arbiter.sv | 129 ++++++++++++
 tb/tb_ddr3_native_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_native_arbiter.sv
// ddr3_native_arbiter: write/read burst arbiter in front of the MIG
// native UI, issuing one BL8 command per 256-bit beat.
module ddr3_native_arbiter #(
  parameter int ADDR_STEP = 8,
  parameter int CNT_W     = 9
) (
  input  logic         ui_clk,
  input  logic         rst_n,
  input  logic         init_calib_complete,
  input  logic         wr_data_req,
  input  logic         rd_data_req,
  input  logic [2:0]   wr_cmd_rdcmd,
  input  logic [7:0]   wr_cmd_rdbl,
  input  logic [27:0]  wr_cmd_rdaddr,
  output logic         wr_cmd_rden,
  input  logic [2:0]   rd_cmd_rdcmd,
  input  logic [7:0]   rd_cmd_rdbl,
  input  logic [27:0]  rd_cmd_rdaddr,
  output logic         rd_cmd_rden,
  output logic         wr_fifo_rden,
  input  logic [255:0] wr_fifo_rdata,
  output logic         rd_fifo_wren,
  output logic [255:0] rd_fifo_wdata,
  output logic [2:0]   app_cmd,
  output logic [27:0]  app_addr,
  output logic         app_en,
  input  logic         app_rdy,
  output logic [255:0] app_wdf_data,
  output logic         app_wdf_wren,
  output logic         app_wdf_end,
  output logic [31:0]  app_wdf_mask,
  input  logic         app_wdf_rdy,
  input  logic [255:0] app_rd_data,
  input  logic         app_rd_data_valid
);

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t           state_q;
  logic [2:0]       cmd_q;
  logic [7:0]       bl_q;
  logic [27:0]      base_q;
  logic [CNT_W-1:0] cmd_cnt_q;
  logic [CNT_W-1:0] dat_cnt_q;
  logic [CNT_W-1:0] cmd_cnt_d;
  logic [CNT_W-1:0] dat_cnt_d;
  logic [CNT_W-1:0] bl_w;
  logic             last_wr_q;
  logic             wr_done_q;
  logic             rd_done_q;
  logic             busy;
  logic             cmd_acc;
  logic             wdat_acc;
  logic             rdat_acc;
  logic             sel_wr;
  logic [7:0]       sel_bl;

  always_comb begin
    busy      = (state_q == WR) || (state_q == RD);
    bl_w      = CNT_W'(bl_q);
    app_en    = busy && (cmd_cnt_q < bl_w);
    app_wdf_wren = (state_q == WR) && (dat_cnt_q < bl_w);
    cmd_acc   = app_en && app_rdy;
    wdat_acc  = app_wdf_wren && app_wdf_rdy;
    rdat_acc  = (state_q == RD) && app_rd_data_valid
                && (dat_cnt_q < bl_w);
    cmd_cnt_d = cmd_cnt_q + CNT_W'(cmd_acc);
    dat_cnt_d = dat_cnt_q + CNT_W'(wdat_acc || rdat_acc);
    // ties go to whichever type was not served last
    sel_wr    = wr_data_req && (!rd_data_req || !last_wr_q);
    sel_bl    = sel_wr ? wr_cmd_rdbl : rd_cmd_rdbl;
  end

  assign app_cmd       = cmd_q;
  assign app_addr      = base_q + 28'(cmd_cnt_q) * 28'(ADDR_STEP);
  assign app_wdf_data  = wr_fifo_rdata;
  assign app_wdf_end   = app_wdf_wren;
  assign app_wdf_mask  = '0;
  assign wr_fifo_rden  = wdat_acc;
  assign rd_fifo_wren  = app_rd_data_valid;
  assign rd_fifo_wdata = app_rd_data;
  assign wr_cmd_rden   = wr_done_q;
  assign rd_cmd_rden   = rd_done_q;

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      bl_q      <= '0;
      base_q    <= '0;
      cmd_cnt_q <= '0;
      dat_cnt_q <= '0;
      last_wr_q <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (init_calib_complete && (wr_data_req || rd_data_req)) begin
            cmd_q     <= sel_wr ? wr_cmd_rdcmd : rd_cmd_rdcmd;
            bl_q      <= sel_bl;
            base_q    <= sel_wr ? wr_cmd_rdaddr : rd_cmd_rdaddr;
            cmd_cnt_q <= '0;
            dat_cnt_q <= '0;
            last_wr_q <= sel_wr;
            if (sel_bl == 8'd0) state_q <= DONE;
            else if (sel_wr)    state_q <= WR;
            else                state_q <= RD;
          end
        end
        WR, RD: begin
          cmd_cnt_q <= cmd_cnt_d;
          dat_cnt_q <= dat_cnt_d;
          if ((cmd_cnt_d == bl_w) && (dat_cnt_d == bl_w))
            state_q <= DONE;
        end
        DONE: begin
          wr_done_q <= last_wr_q;
          rd_done_q <= !last_wr_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_native_arbiter.sv
// tb_ddr3_native_arbiter: scoreboard bench for the DDR3 burst arbiter
// with a FWFT write FIFO model and a fixed-latency read responder.
module tb_ddr3_native_arbiter;

  logic         ui_clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         init_calib_complete = 1'b0;
  logic         wr_data_req = 1'b0;
  logic         rd_data_req = 1'b0;
  logic [2:0]   wr_cmd_rdcmd = 3'b000;
  logic [7:0]   wr_cmd_rdbl = 8'd0;
  logic [27:0]  wr_cmd_rdaddr = 28'd0;
  logic         wr_cmd_rden;
  logic [2:0]   rd_cmd_rdcmd = 3'b001;
  logic [7:0]   rd_cmd_rdbl = 8'd0;
  logic [27:0]  rd_cmd_rdaddr = 28'd0;
  logic         rd_cmd_rden;
  logic         wr_fifo_rden;
  logic [255:0] wr_fifo_rdata;
  logic         rd_fifo_wren;
  logic [255:0] rd_fifo_wdata;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic         app_en;
  logic         app_rdy = 1'b1;
  logic [255:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_rdy = 1'b1;
  logic [255:0] app_rd_data = '0;
  logic         app_rd_data_valid = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int wptr = 0;
  int exp_wseq = 0;
  int rseq = 0;
  int n_cmd = 0;
  int n_pop = 0;
  int last_valid_cyc = 0;
  int done_cyc = 0;
  int grant_cyc = 0;
  int bp_start = 0;
  bit bp_mode = 1'b0;

  logic [30:0]  exp_cmd[$];
  logic [255:0] exp_wdata[$];
  logic [255:0] exp_rdata[$];
  bit           exp_done[$];
  int           rsp_q[$];

  ddr3_native_arbiter #(.ADDR_STEP(8), .CNT_W(9)) dut (
    .ui_clk(ui_clk),
    .rst_n(rst_n),
    .init_calib_complete(init_calib_complete),
    .wr_data_req(wr_data_req),
    .rd_data_req(rd_data_req),
    .wr_cmd_rdcmd(wr_cmd_rdcmd),
    .wr_cmd_rdbl(wr_cmd_rdbl),
    .wr_cmd_rdaddr(wr_cmd_rdaddr),
    .wr_cmd_rden(wr_cmd_rden),
    .rd_cmd_rdcmd(rd_cmd_rdcmd),
    .rd_cmd_rdbl(rd_cmd_rdbl),
    .rd_cmd_rdaddr(rd_cmd_rdaddr),
    .rd_cmd_rden(rd_cmd_rden),
    .wr_fifo_rden(wr_fifo_rden),
    .wr_fifo_rdata(wr_fifo_rdata),
    .rd_fifo_wren(rd_fifo_wren),
    .rd_fifo_wdata(rd_fifo_wdata),
    .app_cmd(app_cmd),
    .app_addr(app_addr),
    .app_en(app_en),
    .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid)
  );

  always #5 ui_clk = ~ui_clk;

  function automatic logic [255:0] wdat(input int s);
    return {8{32'hA500_0000 ^ s}};
  endfunction

  function automatic logic [255:0] rdat(input int s);
    return {8{32'hD000_0000 ^ s}};
  endfunction

  assign wr_fifo_rdata = wdat(wptr);

  always @(posedge ui_clk)
    if (wr_fifo_rden) wptr <= wptr + 1;

  task automatic check(input string tag, input logic [255:0] act,
                       input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ready shaping and read responder (20-cycle latency per command)
  initial forever begin
    @(posedge ui_clk);
    cyc++;
    #1;
    app_rdy = bp_mode ? cyc[0] : 1'b1;
    app_wdf_rdy = !bp_mode || (cyc >= bp_start + 10);
    if (rsp_q.size() > 0 && rsp_q[0] <= cyc) begin
      void'(rsp_q.pop_front());
      app_rd_data_valid = 1'b1;
      app_rd_data = rdat(rseq);
      exp_rdata.push_back(rdat(rseq));
      rseq++;
    end else begin
      app_rd_data_valid = 1'b0;
    end
  end

  bit          hold_q = 1'b0;
  logic [27:0] hold_addr = '0;
  bit          prev_rden = 1'b0;

  initial forever begin
    logic [30:0] e;
    @(negedge ui_clk);
    if (!rst_n) begin
      hold_q = 1'b0;
      prev_rden = 1'b0;
    end else begin
      if (hold_q) check("addr_hold", {app_en, app_addr}, {1'b1, hold_addr});
      hold_q = app_en && !app_rdy;
      hold_addr = app_addr;
      if (app_en && app_rdy) begin
        n_cmd++;
        if (exp_cmd.size() == 0) begin
          check("cmd_extra", 256'(exp_cmd.size()), 256'd1);
        end else begin
          e = exp_cmd.pop_front();
          check("app_addr", app_addr, e[27:0]);
          check("app_cmd", app_cmd, e[30:28]);
        end
        if (app_cmd == 3'b001) rsp_q.push_back(cyc + 20);
      end
      if (wr_fifo_rden) n_pop++;
      if (app_wdf_wren && app_wdf_rdy) begin
        check("wdf_end", app_wdf_end, 1'b1);
        if (exp_wdata.size() == 0)
          check("wdata_extra", 256'(exp_wdata.size()), 256'd1);
        else
          check("wdf_data", app_wdf_data, exp_wdata.pop_front());
      end
      if (app_rd_data_valid || rd_fifo_wren) begin
        check("rd_wren", rd_fifo_wren, app_rd_data_valid);
        if (exp_rdata.size() == 0)
          check("rdata_extra", 256'(exp_rdata.size()), 256'd1);
        else
          check("rd_data", rd_fifo_wdata, exp_rdata.pop_front());
        last_valid_cyc = cyc;
      end
      if (wr_cmd_rden || rd_cmd_rden) begin
        check("rden_gap", prev_rden, 1'b0);
        check("rden_both", wr_cmd_rden && rd_cmd_rden, 1'b0);
        if (exp_done.size() == 0)
          check("rden_extra", 256'(exp_done.size()), 256'd1);
        else
          check("rden_type", wr_cmd_rden, exp_done.pop_front());
        if (rd_cmd_rden)
          check("rd_done_lat", 256'(cyc - last_valid_cyc), 256'd2);
        done_cyc = cyc;
      end
      prev_rden = wr_cmd_rden || rd_cmd_rden;
    end
  end

  task automatic load_cmd(input bit w, input int bl, input logic [27:0] a);
    if (w) begin
      wr_cmd_rdbl = 8'(bl);
      wr_cmd_rdaddr = a;
    end else begin
      rd_cmd_rdbl = 8'(bl);
      rd_cmd_rdaddr = a;
    end
  endtask

  task automatic push_exp(input bit w, input int bl, input logic [27:0] a);
    for (int i = 0; i < bl; i++) begin
      exp_cmd.push_back({w ? 3'b000 : 3'b001, a + 28'(i * 8)});
      if (w) begin
        exp_wdata.push_back(wdat(exp_wseq));
        exp_wseq++;
      end
    end
    exp_done.push_back(w);
  endtask

  task automatic req_pulse(input bit w);
    @(posedge ui_clk);
    #2;
    if (w) wr_data_req = 1'b1;
    else   rd_data_req = 1'b1;
    grant_cyc = cyc;
    @(posedge ui_clk);
    #2;
    wr_data_req = 1'b0;
    rd_data_req = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while ((exp_cmd.size() + exp_wdata.size() + exp_rdata.size()
            + exp_done.size()) > 0 && k < bound) begin
      @(posedge ui_clk);
      k++;
    end
    check("idle_timeout", 256'(exp_cmd.size() + exp_wdata.size()
          + exp_rdata.size() + exp_done.size()), 256'd0);
    repeat (3) @(posedge ui_clk);
    #2;
  endtask

  task automatic run_burst(input bit w, input int bl, input logic [27:0] a);
    load_cmd(w, bl, a);
    push_exp(w, bl, a);
    req_pulse(w);
    wait_idle(3000);
  endtask

  initial begin
    int n0;
    int p0;
    int r0;
    int k;
    repeat (3) @(posedge ui_clk);
    #2;
    check("rst_app_en", app_en, 1'b0);
    check("rst_wdf_wren", app_wdf_wren, 1'b0);
    check("rst_wdf_end", app_wdf_end, 1'b0);
    check("rst_fifo_rden", wr_fifo_rden, 1'b0);
    check("rst_rd_wren", rd_fifo_wren, 1'b0);
    check("rst_wr_rden", wr_cmd_rden, 1'b0);
    check("rst_rd_rden", rd_cmd_rden, 1'b0);
    check("rst_app_cmd", app_cmd, 3'b000);
    check("rst_app_addr", app_addr, 28'd0);
    check("rst_mask", app_wdf_mask, 32'd0);
    rst_n = 1'b1;

    // no grant before calibration
    wr_cmd_rdbl = 8'd8;
    n0 = n_cmd;
    wr_data_req = 1'b1;
    repeat (20) @(posedge ui_clk);
    #2;
    check("calib_nogrant", 256'(n_cmd - n0), 256'd0);
    check("calib_nodone", 256'(exp_done.size()), 256'd0);
    wr_data_req = 1'b0;
    init_calib_complete = 1'b1;
    repeat (2) @(posedge ui_clk);

    p0 = n_pop;
    run_burst(1'b1, 64, 28'h000_0200);
    check("wr_pops", 256'(n_pop - p0), 256'd64);

    n0 = n_cmd;
    p0 = n_pop;
    bp_start = cyc + 2;
    bp_mode = 1'b1;
    run_burst(1'b1, 64, 28'h000_0400);
    bp_mode = 1'b0;
    check("bp_cmds", 256'(n_cmd - n0), 256'd64);
    check("bp_pops", 256'(n_pop - p0), 256'd64);

    r0 = rseq;
    run_burst(1'b0, 64, 28'h000_0000);
    check("rd_beats", 256'(rseq - r0), 256'd64);

    // both requests held: W,R,W,R
    load_cmd(1'b1, 4, 28'h000_8000);
    load_cmd(1'b0, 4, 28'h000_9000);
    push_exp(1'b1, 4, 28'h000_8000);
    push_exp(1'b0, 4, 28'h000_9000);
    push_exp(1'b1, 4, 28'h000_8000);
    push_exp(1'b0, 4, 28'h000_9000);
    n0 = n_cmd;
    @(posedge ui_clk);
    #2;
    wr_data_req = 1'b1;
    rd_data_req = 1'b1;
    k = 0;
    while (n_cmd < n0 + 13 && k < 1000) begin
      @(posedge ui_clk);
      #2;
      k++;
    end
    check("tie_started", n_cmd >= n0 + 13, 1'b1);
    wr_data_req = 1'b0;
    rd_data_req = 1'b0;
    wait_idle(3000);

    run_burst(1'b1, 2, 28'hFFF_FFF8);

    n0 = n_cmd;
    run_burst(1'b1, 0, 28'h000_0100);
    check("bl0_lat", 256'(done_cyc - grant_cyc), 256'd2);
    check("bl0_noen", 256'(n_cmd - n0), 256'd0);

    // reset in the middle of a write burst
    load_cmd(1'b1, 64, 28'h000_4000);
    push_exp(1'b1, 64, 28'h000_4000);
    n0 = n_cmd;
    req_pulse(1'b1);
    k = 0;
    while (n_cmd < n0 + 30 && k < 500) begin
      @(negedge ui_clk);
      k++;
    end
    check("rst_reached30", n_cmd >= n0 + 30, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_app_en", app_en, 1'b0);
    check("mid_wdf_wren", app_wdf_wren, 1'b0);
    check("mid_fifo_rden", wr_fifo_rden, 1'b0);
    check("mid_wr_rden", wr_cmd_rden, 1'b0);
    check("mid_app_addr", app_addr, 28'd0);
    exp_cmd.delete();
    exp_wdata.delete();
    exp_done.delete();
    exp_wseq = wptr;
    repeat (3) @(posedge ui_clk);
    #2;
    rst_n = 1'b1;
    n0 = n_cmd;
    repeat (6) @(posedge ui_clk);
    #2;
    check("post_rst_quiet", 256'(n_cmd - n0), 256'd0);
    run_burst(1'b1, 4, 28'h000_1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
